// File: rtl/mipi_frame_ctrl_pkg.sv
// Shared definitions for the CSI-2 frame sequencer: FSM encoding and default geometry.
// Optional word-per-line checking is enabled by defining MIPI_FRAME_CTRL_LINE_CHECK_EN.
package mipi_frame_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam int H_WORDS_DEF = 960;
  localparam int V_LINES_DEF = 1080;
  localparam int NUM_BUF_DEF = 3;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;
endpackage

// File: rtl/mipi_geom_cnt.sv
// Line/word geometry counters and sticky frame error flag.
// Word counting exists only when MIPI_FRAME_CTRL_LINE_CHECK_EN is defined.
module mipi_geom_cnt
  import mipi_frame_ctrl_pkg::*;
#(
  parameter int H_WORDS = H_WORDS_DEF,
  parameter int V_LINES = V_LINES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        word_en,
  input  logic        line_start,
  input  logic        drop,
  input  logic        line_chk,
  output logic [15:0] line_cnt,
  output logic        bad
);
  localparam logic [15:0] V_MAX = 16'(V_LINES);
  localparam logic [15:0] V_SAT = 16'(V_LINES + 1);

  logic err;
  logic word_err;

`ifdef MIPI_FRAME_CTRL_LINE_CHECK_EN
  logic [15:0] word_cnt;

  // The line_start word itself is the first word of the new line.
  assign word_err = line_chk && (word_cnt != 16'(H_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (clr) begin
      word_cnt <= '0;
    end else if (word_en) begin
      if (line_start)
        word_cnt <= 16'd1;
      else if (word_cnt != 16'hFFFF)
        word_cnt <= word_cnt + 16'd1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = line_chk & (H_WORDS > 0);
  assign word_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      line_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (line_start) begin
        if (line_cnt == V_MAX)
          err <= 1'b1;
        if (line_cnt != V_SAT)
          line_cnt <= line_cnt + 16'd1;
      end
      if (drop || word_err)
        err <= 1'b1;
    end
  end

  // Includes a line-length failure detected this very cycle, so CHECK sees it.
  assign bad = err | word_err;
endmodule

// File: rtl/mipi_frame_ctrl.sv
// Frame sequencer between the CSI-2 RAW unpacker and the DDR3 frame-buffer writer.
// Define MIPI_FRAME_CTRL_LINE_CHECK_EN to also check words per line.
module mipi_frame_ctrl
  import mipi_frame_ctrl_pkg::*;
#(
  parameter int H_WORDS = H_WORDS_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int NUM_BUF = NUM_BUF_DEF
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        enable,
  input  logic        raw_vld,
  input  logic [15:0] raw_data,
  input  logic        raw_vsync,
  input  logic        ddr_rdy,
  output logic        pix_vld,
  output logic [15:0] pix_data,
  output logic        frame_sof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  buf_idx,
  output logic [1:0]  state_o,
  output logic [15:0] last_lines,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);
  state_t      state, state_nxt;
  logic        vsync_r1, vld_r1;
  logic        vs_fall, vs_rise, line_start;
  logic        active, fwd, sof_set, line_chk, bad;
  logic [15:0] line_cnt;

  assign vs_fall    = vsync_r1 & ~raw_vsync;
  assign vs_rise    = ~vsync_r1 & raw_vsync;
  assign line_start = ~vld_r1 & raw_vld;
  assign active     = (state == ACTIVE);
  assign fwd        = active & raw_vld & ddr_rdy;
  // A line still open when vsync rises is judged during CHECK.
  assign line_chk   = (active & vld_r1 & ~raw_vld) | ((state == CHECK) & vld_r1);
  assign state_o    = state;

  mipi_geom_cnt #(
    .H_WORDS(H_WORDS),
    .V_LINES(V_LINES)
  ) u_geom (
    .clk       (sclk),
    .rst       (s_rst),
    .clr       (sof_set),
    .word_en   (active & raw_vld),
    .line_start(active & line_start),
    .drop      (active & raw_vld & ~ddr_rdy),
    .line_chk  (line_chk),
    .line_cnt  (line_cnt),
    .bad       (bad)
  );

  always_comb begin
    state_nxt  = state;
    sof_set    = 1'b0;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (vs_fall) begin
          state_nxt = ACTIVE;
          sof_set   = 1'b1;
        end
      end
      ACTIVE:  if (vs_rise) state_nxt = CHECK;
      CHECK: begin
        frame_done = 1'b1;
        frame_ok   = (line_cnt == 16'(V_LINES)) & ~bad;
        state_nxt  = enable ? WAIT_VS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state      <= IDLE;
      vsync_r1   <= 1'b1;
      vld_r1     <= 1'b0;
      frame_sof  <= 1'b0;
      pix_vld    <= 1'b0;
      pix_data   <= '0;
      buf_idx    <= '0;
      last_lines <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      vsync_r1  <= raw_vsync;
      vld_r1    <= raw_vld;
      frame_sof <= sof_set;
      pix_vld   <= fwd;
      if (fwd)
        pix_data <= raw_data;
      // Bad frames keep the buffer so the writer overwrites it next time.
      if (frame_done) begin
        last_lines <= line_cnt;
        if (frame_ok) begin
          buf_idx   <= (buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 : buf_idx + 2'd1;
          frame_cnt <= frame_cnt + 16'd1;
        end else if (err_cnt != ERR_CNT_MAX) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mipi_frame_ctrl.sv
// Self-checking bench for mipi_frame_ctrl: frame table plus hand-written corner sequences.
// Expected short-line result follows MIPI_FRAME_CTRL_LINE_CHECK_EN.
module tb_mipi_frame_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  localparam int NB = 3;
`ifdef MIPI_FRAME_CTRL_LINE_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        s_rst, enable, raw_vld, raw_vsync, ddr_rdy;
  logic [15:0] raw_data;
  logic        pix_vld, frame_sof, frame_done, frame_ok;
  logic [15:0] pix_data, last_lines, frame_cnt;
  logic [1:0]  buf_idx, state_o;
  logic [7:0]  err_cnt;

  mipi_frame_ctrl #(.H_WORDS(H), .V_LINES(V), .NUM_BUF(NB)) dut (
    .sclk(sclk), .s_rst(s_rst), .enable(enable), .raw_vld(raw_vld),
    .raw_data(raw_data), .raw_vsync(raw_vsync), .ddr_rdy(ddr_rdy),
    .pix_vld(pix_vld), .pix_data(pix_data), .frame_sof(frame_sof),
    .frame_done(frame_done), .frame_ok(frame_ok), .buf_idx(buf_idx),
    .state_o(state_o), .last_lines(last_lines), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    int lines; int short_line; int drop_line; int drop_n; int en_drop;
    bit exp_ok; int exp_lines; int exp_pix;
  } frame_vec_t;
  typedef struct { bit ok; int lines; int bidx; int fcnt; int errc; } frame_exp_t;
  typedef struct { logic [15:0] data; int cyc; } pix_exp_t;

  pix_exp_t   pix_q[$];
  frame_exp_t frame_q[$];
  frame_exp_t pend;
  bit         pend_valid = 1'b0;
  int vectors = 0, miscompares = 0;
  int cyc = 0, pix_seen = 0, sof_seen = 0;
  int m_bidx = 0, m_fcnt = 0, m_errc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  // Output monitor: pops scoreboard entries as the DUT produces results.
  always @(negedge sclk) begin
    if (pend_valid) begin
      check("last_lines", last_lines, pend.lines);
      check("buf_idx", buf_idx, pend.bidx);
      check("frame_cnt", frame_cnt, pend.fcnt);
      check("err_cnt", err_cnt, pend.errc);
      pend_valid = 1'b0;
    end
    if (pix_vld) begin
      pix_seen++;
      if (pix_q.size() == 0) begin
        check("pix_unexpected", pix_vld, 0);
      end else begin
        pix_exp_t e;
        e = pix_q.pop_front();
        check("pix_data", pix_data, e.data);
        check("pix_latency", cyc, e.cyc);
      end
    end
    if (frame_sof) sof_seen++;
    if (frame_done) begin
      check("sof_with_done", frame_sof, 0);
      if (frame_q.size() == 0) begin
        check("done_unexpected", frame_done, 0);
      end else begin
        pend = frame_q.pop_front();
        check("frame_ok", frame_ok, pend.ok);
        pend_valid = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_frame(input frame_vec_t v);
    frame_exp_t fe;
    int nw;
    raw_vsync = 1'b0;
    tick(); tick();
    for (int l = 0; l < v.lines; l++) begin
      if (l == v.en_drop) enable = 1'b0;
      nw = (l == v.short_line) ? H - 1 : H;
      for (int w = 0; w < nw; w++) begin
        raw_vld  = 1'b1;
        raw_data = 16'($urandom);
        ddr_rdy  = !(l == v.drop_line && w < v.drop_n);
        if (ddr_rdy) pix_q.push_back('{raw_data, cyc + 1});
        tick();
      end
      raw_vld = 1'b0;
      ddr_rdy = 1'b1;
      tick(); tick();
    end
    if (v.exp_ok) begin
      m_bidx = (m_bidx + 1) % NB;
      m_fcnt = (m_fcnt + 1) & 16'hFFFF;
    end else if (m_errc < 255) begin
      m_errc++;
    end
    fe = '{v.exp_ok, v.exp_lines, m_bidx, m_fcnt, m_errc};
    frame_q.push_back(fe);
    raw_vsync = 1'b1;
    repeat (4) tick();
  endtask

  frame_vec_t vecs[9];
  frame_vec_t bad0;
  int pix0, sof0;

  initial begin
    vecs[0] = '{4, -1, -1, 0, -1, 1'b1, 4, 32};
    vecs[1] = '{4, -1, -1, 0, -1, 1'b1, 4, 32};
    vecs[2] = '{4, -1, -1, 0, -1, 1'b1, 4, 32};
    vecs[3] = '{3, -1, -1, 0, -1, 1'b0, 3, 24};
    vecs[4] = '{5, -1, -1, 0, -1, 1'b0, 5, 40};
    vecs[5] = '{4, -1,  1, 2, -1, 1'b0, 4, 30};
    vecs[6] = '{4, -1, -1, 0, -1, 1'b1, 4, 32};
    vecs[7] = '{4,  2, -1, 0, -1, !LCHK, 4, 31};
    vecs[8] = '{4, -1, -1, 0,  1, 1'b1, 4, 32};
    bad0    = '{0, -1, -1, 0, -1, 1'b0, 0, 0};

    s_rst = 1'b1; enable = 1'b0; raw_vld = 1'b0; raw_data = '0;
    raw_vsync = 1'b1; ddr_rdy = 1'b1;
    #3;
    check("rst_state", state_o, 0);
    check("rst_pix_vld", pix_vld, 0);
    check("rst_buf_idx", buf_idx, 0);
    check("rst_counts", {frame_cnt, err_cnt}, 0);
    tick(); tick();
    s_rst = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    check("state_wait_vs", state_o, 1);

    for (int i = 0; i < 9; i++) begin
      pix0 = pix_seen; sof0 = sof_seen;
      send_frame(vecs[i]);
      check($sformatf("pix_count_%0d", i), pix_seen - pix0, vecs[i].exp_pix);
      check($sformatf("sof_count_%0d", i), sof_seen - sof0, 1);
      if (i == 2) begin
        check("buf_wrap", buf_idx, 0);
        check("three_good", frame_cnt, 3);
      end
      if (vecs[i].en_drop >= 0) begin
        check("state_idle_after_drop", state_o, 0);
        enable = 1'b1;
        tick(); tick();
      end
    end

    // Enable arrives mid-frame: that frame must be skipped entirely.
    enable = 1'b0;
    tick(); tick();
    sof0 = sof_seen;
    raw_vsync = 1'b0;
    tick(); tick();
    for (int w = 0; w < H; w++) begin
      if (w == 3) enable = 1'b1;
      raw_vld = 1'b1; raw_data = 16'($urandom);
      tick();
    end
    raw_vld = 1'b0;
    tick(); tick();
    raw_vsync = 1'b1;
    repeat (4) tick();
    check("sof_midframe_enable", sof_seen - sof0, 0);
    check("state_midframe_enable", state_o, 1);
    send_frame(vecs[0]);
    check("sof_after_midframe", sof_seen - sof0, 1);

    // Asynchronous reset in the middle of a frame.
    raw_vsync = 1'b0;
    tick(); tick();
    for (int w = 0; w < H; w++) begin
      raw_vld = 1'b1; raw_data = 16'($urandom);
      pix_q.push_back('{raw_data, cyc + 1});
      tick();
    end
    raw_vld = 1'b0;
    tick(); tick();
    check("pre_rst_active", state_o, 2);
    #2 s_rst = 1'b1;
    #1;
    check("mrst_state", state_o, 0);
    check("mrst_pix", {pix_vld, pix_data}, 0);
    check("mrst_pulses", {frame_sof, frame_done, frame_ok}, 0);
    check("mrst_buf_idx", buf_idx, 0);
    check("mrst_last_lines", last_lines, 0);
    check("mrst_frame_cnt", frame_cnt, 0);
    check("mrst_err_cnt", err_cnt, 0);
    m_bidx = 0; m_fcnt = 0; m_errc = 0;
    raw_vsync = 1'b1;
    tick();
    s_rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 256; i++) send_frame(bad0);
    check("err_cnt_saturated", err_cnt, 255);

    repeat (4) tick();
    check("pix_queue_drained", pix_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mipi_frame_ctrl.md
Name: mipi_frame_ctrl

Overview:
- Frame-level sequencer between the CSI-2 RAW unpacker (raw_vld/raw_data/raw_vsync) and the DDR3 frame-buffer writer.
- Arms on software enable, aligns to a clean frame start and forwards pixel words.
- Checks line and word geometry and reports frame boundaries to the writer.
- Rotates the DDR frame-buffer index only on good frames; bad frames re-use the current buffer.

Parameters:
- H_WORDS, 960, 16-bit words per line (1920 px / 2).
- V_LINES, 1080, lines per frame.
- NUM_BUF, 3, DDR frame buffers (2..4).

Ports:
- sclk  in  1  system clock
- s_rst  in  1  asynchronous active-high reset
- enable  in  1  capture enable, level
- raw_vld  in  1  pixel word valid, high for one line burst
- raw_data  in  16  pixel word
- raw_vsync  in  1  vertical blanking level, high between frames
- ddr_rdy  in  1  writer FIFO can accept a word this cycle
- pix_vld  out  1  forwarded word valid
- pix_data  out  16  forwarded word
- frame_sof  out  1  one-cycle start-of-frame pulse
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_ok  out  1  result, valid with frame_done
- buf_idx  out  2  current DDR buffer index
- state_o  out  2  FSM state
- last_lines  out  16  line count of the last finished frame
- frame_cnt  out  16  good frames, wraps
- err_cnt  out  8  bad frames, saturates at 255

Behaviour:
- Reset values: all outputs 0; state IDLE; internal raw_vsync_r1=1 and raw_vld_r1=0, so no false edge is detected after reset.
- Edges: vs_fall = raw_vsync_r1 & ~raw_vsync; vs_rise = ~raw_vsync_r1 & raw_vsync; line_start = ~raw_vld_r1 & raw_vld.
- State encoding: IDLE=0, WAIT_VS=1, ACTIVE=2, CHECK=3.
- IDLE:
  - enable=1 -> WAIT_VS next cycle.
- WAIT_VS:
  - Waits for vs_fall. Enabling mid-frame therefore skips the partial frame.
  - enable=0 -> IDLE.
  - On vs_fall -> ACTIVE; frame_sof=1 in the first ACTIVE cycle; line_cnt, word_cnt and the err flag are cleared.
- ACTIVE, per cycle with raw_vld=1:
  - ddr_rdy=1 -> pix_vld=1, pix_data=raw_data on the next cycle (latency 1).
  - ddr_rdy=0 -> word dropped, pix_vld=0, err set.
  - line_start increments line_cnt (16-bit). A line_start when line_cnt==V_LINES sets err; line_cnt saturates at V_LINES+1.
  - vs_rise -> CHECK. A raw_vld in the same cycle is still forwarded and counted.
  - enable=0 in ACTIVE does not abort; the frame completes, then CHECK.
- CHECK, one cycle:
  - frame_done=1.
  - frame_ok = (line_cnt==V_LINES) & ~err.
  - last_lines=line_cnt.
  - ok -> buf_idx=(buf_idx==NUM_BUF-1)?0:buf_idx+1, frame_cnt+1.
  - bad -> buf_idx unchanged, err_cnt+1 saturating.
  - Next state: WAIT_VS if enable, else IDLE. Next frame_sof needs a new vs_fall.
- Outside ACTIVE, raw_vld is ignored: pix_vld=0, no counting.
- frame_sof and frame_done can never occur in the same cycle.
- Reset mid-frame returns to IDLE immediately. Counters and buf_idx clear; the writer discards any partial frame.

Optional Feature:
- Macro MIPI_FRAME_CTRL_LINE_CHECK_EN.
- Defined:
  - word_cnt counts raw_vld cycles per line and clears on line_start.
  - At each raw_vld falling edge inside ACTIVE, word_cnt!=H_WORDS sets err.
  - A line still open at vs_rise is checked in CHECK.
- Undefined:
  - word_cnt logic is absent; only the line count and ddr_rdy drops affect frame_ok.

Decomposition:
- Package mipi_frame_ctrl_pkg holds:
  - state encoding constants IDLE/WAIT_VS/ACTIVE/CHECK;
  - default H_WORDS/V_LINES/NUM_BUF;
  - ERR_CNT_MAX=255.
- One sub-module, mipi_geom_cnt: line_cnt/word_cnt counters with saturation and the err flag. It has a clear input and an input for the per-line word check.
- The FSM, buffer rotation and forwarding stay in the top.

Test Plan:
Bench uses H_WORDS=8, V_LINES=4, NUM_BUF=3, line check enabled.
- Good frames: enable=1 with vsync high; three vsync-low frames of 4 lines x 8 words -> three frame_sof pulses; frame_done with frame_ok=1; buf_idx 0->1->2->0; frame_cnt=3; 96 pix_vld cycles, each one cycle after raw_vld with data equal.
- Short frame: frame of 3 lines -> frame_ok=0, last_lines=3, err_cnt=1, buf_idx unchanged.
- Long frame: frame of 5 lines -> frame_ok=0, last_lines=5 (saturated at V_LINES+1), err_cnt=1, buf_idx unchanged.
- Backpressure: ddr_rdy=0 for 2 words in line 2 -> 30 pix_vld only, frame_ok=0; the next good frame has frame_ok=1.
- Short line: one line of 7 words -> frame_ok=0. The same stimulus with the macro undefined -> frame_ok=1.
- Enable and reset timing:
  - enable asserted mid-frame -> no frame_sof until the next vs_fall.
  - enable dropped in ACTIVE -> frame completes with frame_done, then state_o=IDLE.
  - s_rst pulsed mid-frame -> all outputs 0 immediately.
  - err_cnt holds at 255 after 256 bad frames.
